// File: rtl/ptr_seq_resp.sv
// Pointer-sequence responder: node table lookup, 2-stage pipe, output FIFO with overflow flag.
// Optional RESP_STATS_EN adds saturating request/drop counters (stat_req, stat_drop).
module ptr_seq_resp #(
  parameter int PTR_W      = 8,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NULL_PTR   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PTR_W-1:0]            in_ptr,
  input  logic                        in_ptr_vld,
  input  logic                        cfg_we,
  input  logic [PTR_W-1:0]            cfg_addr,
  input  logic [PTR_W-1:0]            cfg_next,
  input  logic [DATA_W-1:0]           cfg_data,
  output logic                        resp_vld,
  input  logic                        resp_rdy,
  output logic [PTR_W-1:0]            resp_ptr,
  output logic [PTR_W-1:0]            resp_next,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_last,
  output logic                        resp_err,
  output logic                        ovf_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_lvl
`ifdef RESP_STATS_EN
  ,
  output logic [15:0]                 stat_req,
  output logic [15:0]                 stat_drop
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FI_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W = FI_W + 1;
  localparam int ENT_W = 2 * PTR_W + DATA_W + 2;

  logic [PTR_W-1:0]  tbl_next [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];

  logic             in_ok;
  logic             cfg_ok;
  logic [IDX_W-1:0] in_idx;
  logic [IDX_W-1:0] cfg_idx;

  assign in_ok   = 32'(in_ptr) < DEPTH;
  assign cfg_ok  = 32'(cfg_addr) < DEPTH;
  assign in_idx  = in_ptr[IDX_W-1:0];
  assign cfg_idx = cfg_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_next[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      tbl_next[cfg_idx] <= cfg_next;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  // Table read shares the write edge, so a same-cycle write is not yet visible (read-before-write).
  logic              s2_vld;
  logic [PTR_W-1:0]  s2_ptr;
  logic [PTR_W-1:0]  s2_next;
  logic [DATA_W-1:0] s2_data;
  logic              s2_err;
  logic              s2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_ptr  <= '0;
      s2_next <= '0;
      s2_data <= '0;
      s2_err  <= 1'b0;
    end else begin
      s2_vld <= in_ptr_vld;
      if (in_ptr_vld) begin
        s2_ptr  <= in_ptr;
        s2_err  <= !in_ok;
        s2_next <= in_ok ? tbl_next[in_idx] : '0;
        s2_data <= in_ok ? tbl_data[in_idx] : '0;
      end
    end
  end

  assign s2_last = (s2_next == PTR_W'(NULL_PTR));

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [FI_W-1:0]  wr_idx;
  logic [FI_W-1:0]  rd_idx;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             drop;

  assign resp_vld = (fifo_lvl != '0);
  assign full     = (fifo_lvl == LVL_W'(FIFO_DEPTH));
  assign pop      = resp_vld && resp_rdy;
  assign do_push  = s2_vld && (!full || pop);
  assign drop     = s2_vld && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_lvl <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_idx] <= {s2_ptr, s2_next, s2_data, s2_last, s2_err};
        wr_idx           <= wr_idx + FI_W'(1);
      end
      if (pop) begin
        rd_idx <= rd_idx + FI_W'(1);
      end
      case ({do_push, pop})
        2'b10:   fifo_lvl <= fifo_lvl + LVL_W'(1);
        2'b01:   fifo_lvl <= fifo_lvl - LVL_W'(1);
        default: fifo_lvl <= fifo_lvl;
      endcase
      if (drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

  assign {resp_ptr, resp_next, resp_data, resp_last, resp_err} = fifo_mem[rd_idx];

`ifdef RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req  <= '0;
      stat_drop <= '0;
    end else begin
      if (in_ptr_vld && (stat_req != 16'hFFFF)) begin
        stat_req <= stat_req + 16'd1;
      end
      if (drop && (stat_drop != 16'hFFFF)) begin
        stat_drop <= stat_drop + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ptr_seq_resp.sv
// Self-checking bench for ptr_seq_resp: directed scenarios plus random traffic against a queue-based model.
module tb_ptr_seq_resp;

  localparam int DEPTH      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int NULL_PTR   = 0;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_ptr;
  logic        in_ptr_vld;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [7:0]  cfg_next;
  logic [15:0] cfg_data;
  logic        resp_vld;
  logic        resp_rdy;
  logic [7:0]  resp_ptr;
  logic [7:0]  resp_next;
  logic [15:0] resp_data;
  logic        resp_last;
  logic        resp_err;
  logic        ovf_err;
  logic [2:0]  fifo_lvl;
`ifdef RESP_STATS_EN
  logic [15:0] stat_req;
  logic [15:0] stat_drop;
`endif

  ptr_seq_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_ptr     (in_ptr),
    .in_ptr_vld (in_ptr_vld),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_next   (cfg_next),
    .cfg_data   (cfg_data),
    .resp_vld   (resp_vld),
    .resp_rdy   (resp_rdy),
    .resp_ptr   (resp_ptr),
    .resp_next  (resp_next),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .ovf_err    (ovf_err),
    .fifo_lvl   (fifo_lvl)
`ifdef RESP_STATS_EN
    ,
    .stat_req   (stat_req),
    .stat_drop  (stat_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ptr;
    logic [7:0]  nxt;
    logic [15:0] data;
    logic        last;
    logic        err;
  } resp_t;

  // Reference model: node table arrays, response queue, one in-flight lookup.
  logic [7:0]  m_next [DEPTH];
  logic [15:0] m_data [DEPTH];
  resp_t       m_q [$];
  bit          m_pend_vld;
  resp_t       m_pend;
  bit          m_ovf;
  int          m_req;
  int          m_drop;
  int          checks;
  int          errors;

  function automatic resp_t lookup(input logic [7:0] p);
    resp_t r;
    r.ptr = p;
    if (p >= DEPTH) begin
      r.err  = 1'b1;
      r.nxt  = 8'd0;
      r.data = 16'd0;
    end else begin
      r.err  = 1'b0;
      r.nxt  = m_next[p[3:0]];
      r.data = m_data[p[3:0]];
    end
    r.last = (r.nxt == 8'(NULL_PTR));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_next[i] = 8'd0;
      m_data[i] = 16'd0;
    end
    m_q.delete();
    m_pend_vld = 0;
    m_pend     = '0;
    m_ovf      = 0;
    m_req      = 0;
    m_drop     = 0;
  endtask

  task automatic model_edge();
    bit pop;
    pop = (m_q.size() > 0) && resp_rdy;
    if (pop) void'(m_q.pop_front());
    if (m_pend_vld) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(m_pend);
      else begin
        m_ovf = 1;
        m_drop++;
      end
    end
    m_pend_vld = in_ptr_vld;
    if (in_ptr_vld) begin
      m_pend = lookup(in_ptr);
      m_req++;
    end
    if (cfg_we && (cfg_addr < DEPTH)) begin
      m_next[cfg_addr[3:0]] = cfg_next;
      m_data[cfg_addr[3:0]] = cfg_data;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    checkOutput("resp_vld", 32'(resp_vld), 32'(m_q.size() > 0));
    checkOutput("fifo_lvl", 32'(fifo_lvl), 32'(m_q.size()));
    checkOutput("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (m_q.size() > 0) begin
      checkOutput("resp_ptr", 32'(resp_ptr), 32'(m_q[0].ptr));
      checkOutput("resp_next", 32'(resp_next), 32'(m_q[0].nxt));
      checkOutput("resp_data", 32'(resp_data), 32'(m_q[0].data));
      checkOutput("resp_last", 32'(resp_last), 32'(m_q[0].last));
      checkOutput("resp_err", 32'(resp_err), 32'(m_q[0].err));
    end
`ifdef RESP_STATS_EN
    checkOutput("stat_req", 32'(stat_req), 32'(m_req));
    checkOutput("stat_drop", 32'(stat_drop), 32'(m_drop));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic applyStimulus(input logic vld, input logic [7:0] ptr, input logic we,
                               input logic [7:0] addr, input logic [7:0] nxt,
                               input logic [15:0] data, input logic rdy);
    in_ptr_vld = vld;
    in_ptr     = ptr;
    cfg_we     = we;
    cfg_addr   = addr;
    cfg_next   = nxt;
    cfg_data   = data;
    resp_rdy   = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic req(input logic [7:0] ptr, input logic rdy);
    applyStimulus(1'b1, ptr, 1'b0, 8'd0, 8'd0, 16'd0, rdy);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 16'd0, rdy);
  endtask

  task automatic write_node(input logic [7:0] addr, input logic [7:0] nxt, input logic [15:0] data);
    applyStimulus(1'b0, 8'd0, 1'b1, addr, nxt, data, 1'b1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    in_ptr_vld = 1'b0;
    in_ptr     = 8'd0;
    cfg_we     = 1'b0;
    cfg_addr   = 8'd0;
    cfg_next   = 8'd0;
    cfg_data   = 16'd0;
    resp_rdy   = 1'b0;
    rst_n      = 1'b1;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_vld", 32'(resp_vld), 32'd0);
    checkOutput("rst_lvl", 32'(fifo_lvl), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_err), 32'd0);
    checkOutput("rst_data", 32'(resp_data), 32'd0);
    checkOutput("rst_ptr", 32'(resp_ptr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      write_node(8'(i), 8'($urandom_range(0, 15)), 16'($urandom));
    end
    write_node(8'd2, 8'd5, 16'h00A2);
    write_node(8'd5, 8'd0, 16'h00A5);

    // Linked-list walk 2 -> 5 with two-cycle latency from request to resp_vld.
    req(8'd2, 1'b1);
    checkOutput("lat_early_vld", 32'(resp_vld), 32'd0);
    req(8'd5, 1'b1);
    checkOutput("lat_vld", 32'(resp_vld), 32'd1);
    checkOutput("n2_ptr", 32'(resp_ptr), 32'd2);
    checkOutput("n2_next", 32'(resp_next), 32'd5);
    checkOutput("n2_data", 32'(resp_data), 32'h00A2);
    checkOutput("n2_last", 32'(resp_last), 32'd0);
    idle(1'b1);
    checkOutput("n5_next", 32'(resp_next), 32'd0);
    checkOutput("n5_data", 32'(resp_data), 32'h00A5);
    checkOutput("n5_last", 32'(resp_last), 32'd1);
    idle(1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      req(8'(i), 1'b1);
      if (i >= 1) checkOutput("stream_vld", 32'(resp_vld), 32'd1);
    end
    repeat (3) idle(1'b1);
    checkOutput("stream_ovf", 32'(ovf_err), 32'd0);

    // Overflow: six requests into a stalled four-entry FIFO.
    for (int i = 0; i < 6; i++) begin
      req(8'(10 + i), 1'b0);
    end
    repeat (2) idle(1'b0);
    checkOutput("ovf_lvl", 32'(fifo_lvl), 32'd4);
    checkOutput("ovf_flag", 32'(ovf_err), 32'd1);
    checkOutput("ovf_head", 32'(resp_ptr), 32'd10);
`ifdef RESP_STATS_EN
    checkOutput("ovf_stat_drop", 32'(stat_drop), 32'd2);
`endif
    repeat (6) idle(1'b1);

    // Out-of-range pointer.
    req(8'd20, 1'b1);
    idle(1'b1);
    checkOutput("oor_err", 32'(resp_err), 32'd1);
    checkOutput("oor_next", 32'(resp_next), 32'd0);
    checkOutput("oor_data", 32'(resp_data), 32'd0);
    checkOutput("oor_last", 32'(resp_last), 32'd1);
    idle(1'b1);

    // Read-before-write on node 3.
    write_node(8'd3, 8'd4, 16'h0033);
    applyStimulus(1'b1, 8'd3, 1'b1, 8'd3, 8'd7, 16'h0037, 1'b1);
    req(8'd3, 1'b1);
    checkOutput("rbw_old_next", 32'(resp_next), 32'd4);
    idle(1'b1);
    checkOutput("rbw_new_next", 32'(resp_next), 32'd7);
    checkOutput("rbw_new_data", 32'(resp_data), 32'h0037);
    idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 19)),
                    $urandom_range(0, 3) == 0, 8'($urandom_range(0, 19)),
                    8'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 2) != 0);
    end
    repeat (6) idle(1'b1);

    // Asynchronous reset with three responses queued.
    for (int i = 0; i < 3; i++) begin
      req(8'(i), 1'b0);
    end
    repeat (2) idle(1'b0);
    checkOutput("pre_rst_lvl", 32'(fifo_lvl), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_vld", 32'(resp_vld), 32'd0);
    checkOutput("mid_rst_lvl", 32'(fifo_lvl), 32'd0);
    checkOutput("mid_rst_ovf", 32'(ovf_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req(8'd2, 1'b1);
    idle(1'b1);
    checkOutput("post_rst_data", 32'(resp_data), 32'd0);
    checkOutput("post_rst_last", 32'(resp_last), 32'd1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
